// File: rtl/line_buffer_pkg.sv
// Shared constants and helpers for the multi-tap line buffer.
package line_buffer_pkg;

   localparam int MIN_ROW_LEN = 2;

   function automatic int addr_w(input int max_len);
      return (max_len > 1) ? $clog2(max_len) : 1;
   endfunction

   function automatic int slice_w(input int ch, input int data_w);
      return ch * data_w;
   endfunction

endpackage

// File: rtl/lb_sdp_ram.sv
// Simple dual-port storage: one write port, one synchronous read port, no output register.
module lb_sdp_ram #(
   parameter int ADDR_W = 10,
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 1024
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/line_buffer_multi.sv
// Multi-row line buffer: TAPS delayed rows of CH-channel beats from one cascaded RAM.
// Define LINE_BUFFER_OUT_REG_EN to add an output register stage (2-cycle latency).
module line_buffer_multi
   import line_buffer_pkg::*;
#(
   parameter int  DATA_W  = 8,
   parameter int  CH      = 2,
   parameter int  TAPS    = 2,
   parameter int  MAX_LEN = 1024,
   localparam int ADDR_W  = addr_w(MAX_LEN)
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        clr,
   input  logic [ADDR_W:0]             row_len,
   input  logic                        din_valid,
   input  logic [CH*DATA_W-1:0]        din,
   output logic                        dout_valid,
   output logic [TAPS*CH*DATA_W-1:0]   dout_tap,
   output logic [ADDR_W-1:0]           col,
   output logic                        primed
);

   localparam int SW     = slice_w(CH, DATA_W);
   localparam int RW     = TAPS * SW;
   localparam int FILL_W = ADDR_W + 1 + $clog2(TAPS + 1);
`ifdef LINE_BUFFER_OUT_REG_EN
   localparam int STAGES = 2;
`else
   localparam int STAGES = 1;
`endif
   localparam logic [ADDR_W:0] LEN_MIN = (ADDR_W+1)'(MIN_ROW_LEN);
   localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(MAX_LEN);

   typedef struct packed {
      logic [TAPS-1:0]   tap_ok;
      logic              primed;
      logic [ADDR_W-1:0] col;
   } meta_t;

   function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] l);
      if (l < LEN_MIN) return LEN_MIN;
      if (l > LEN_MAX) return LEN_MAX;
      return l;
   endfunction

   logic [ADDR_W:0]         len_q;
   logic [ADDR_W-1:0]       ptr;
   logic [ADDR_W-1:0]       last_col;
   logic [FILL_W-1:0]       fill;
   logic [FILL_W-1:0]       fill_max;
   logic                    acc;
   logic [STAGES:1]         vld_pipe;
   logic [TAPS-1:0]         tap_ok_nxt;
   meta_t                   m1;
   logic                    wr_en;
   logic [ADDR_W-1:0]       wr_addr;
   logic [SW-1:0]           din_q;
   logic [TAPS-1:0][SW-1:0] rd_data;
   logic [TAPS-1:0][SW-1:0] wr_data;
   logic [TAPS-1:0][SW-1:0] tap_m;

   // A beat arriving with clr is dropped, so everything downstream keys off acc.
   assign acc      = din_valid & ~clr;
   assign last_col = ADDR_W'(len_q - 1'b1);
   assign fill_max = FILL_W'(TAPS) * FILL_W'(len_q);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         len_q <= LEN_MAX;
         ptr   <= '0;
         fill  <= '0;
      end else if (clr) begin
         len_q <= clamp_len(row_len);
         ptr   <= '0;
         fill  <= '0;
      end else if (din_valid) begin
         ptr  <= (ptr == last_col) ? '0 : ptr + 1'b1;
         fill <= (fill == fill_max) ? fill : fill + 1'b1;
      end
   end

   // Tap k is real once (k+1) full rows have passed through since the last flush.
   for (genvar k = 0; k < TAPS; k++) begin : g_thr
      assign tap_ok_nxt[k] = (fill >= FILL_W'(k + 1) * FILL_W'(len_q));
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         din_q   <= '0;
      end else begin
         wr_en <= acc;
         if (acc) begin
            wr_addr <= ptr;
            din_q   <= din;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_pipe <= '0;
         m1       <= '0;
      end else if (clr) begin
         vld_pipe <= '0;
         m1       <= '0;
      end else begin
         vld_pipe[1] <= acc;
         for (int s = 2; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
         if (acc) m1 <= '{tap_ok: tap_ok_nxt, primed: (fill == fill_max), col: ptr};
      end
   end

   // Each slot shifts one row deeper on rewrite: new beat into slice 0, old slice k into k+1.
   assign wr_data[0] = din_q;
   if (TAPS > 1) begin : g_casc
      assign wr_data[TAPS-1:1] = rd_data[TAPS-2:0];
   end

   lb_sdp_ram #(
      .ADDR_W (ADDR_W),
      .WIDTH  (RW),
      .DEPTH  (MAX_LEN)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_addr),
      .wdata (wr_data),
      .re    (acc),
      .raddr (ptr),
      .rdata (rd_data)
   );

   for (genvar k = 0; k < TAPS; k++) begin : g_mask
      assign tap_m[k] = m1.tap_ok[k] ? rd_data[k] : '0;
   end

`ifdef LINE_BUFFER_OUT_REG_EN
   logic [RW-1:0]     tap_q;
   logic [ADDR_W-1:0] col_q;
   logic              primed_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tap_q    <= '0;
         col_q    <= '0;
         primed_q <= 1'b0;
      end else if (clr) begin
         tap_q    <= '0;
         col_q    <= '0;
         primed_q <= 1'b0;
      end else if (vld_pipe[1]) begin
         tap_q    <= tap_m;
         col_q    <= m1.col;
         primed_q <= m1.primed;
      end
   end

   assign dout_tap = tap_q;
   assign col      = col_q;
   assign primed   = primed_q;
`else
   // RAM output only changes on a read, so the masked view holds between beats.
   assign dout_tap = tap_m;
   assign col      = m1.col;
   assign primed   = m1.primed;
`endif

   assign dout_valid = vld_pipe[STAGES];

endmodule

// File: doc/line_buffer_multi.md
LINE_BUFFER_MULTI -- requirements
Module: line_buffer_multi

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning bits per channel sample.
REQ-002 SHALL have parameter CH, default 2, meaning parallel channels per beat.
REQ-003 SHALL have parameter TAPS, default 2, meaning delayed rows produced (KxK window uses K-1).
REQ-004 SHALL have parameter MAX_LEN, default 1024, meaning maximum row length in beats; ADDR_W = clog2(MAX_LEN).
REQ-005 SHALL have port clk, input, 1, meaning clock, rising edge.
REQ-006 SHALL have port rstn, input, 1, meaning reset, asynchronous, active-low.
REQ-007 SHALL have port clr, input, 1, meaning synchronous flush and row_len re-latch.
REQ-008 SHALL have port row_len, input, ADDR_W+1, meaning active row length in beats.
REQ-009 SHALL have port din_valid, input, 1, meaning din carries a beat.
REQ-010 SHALL have port din, input, CH*DATA_W, meaning beat; channel 0 in LSBs.
REQ-011 SHALL have port dout_valid, output, 1, meaning dout_tap carries a beat.
REQ-012 SHALL have port dout_tap, output, TAPS*CH*DATA_W, meaning tap k in slice k (tap 0 in LSBs).
REQ-013 SHALL have port col, output, ADDR_W, meaning column index of the beat on dout_tap.
REQ-014 SHALL have port primed, output, 1, meaning every tap holds real data.

Function
REQ-015 SHALL define tap k as the din beat accepted exactly (k+1)*L valid beats earlier, where L is the latched row length.
REQ-016 SHALL advance the circular pointer ptr (0..L-1, wrapping L-1 -> 0) only on din_valid; with din_valid low all state holds.
REQ-017 SHALL read RAM at ptr on din_valid and, one cycle later, write {rd tap0..TAPS-2, registered din} back to the same address (read-before-write cascade).
REQ-018 SHALL assert dout_valid exactly 1 cycle after din_valid (no gaps, no merging); dout_tap and col hold their values while dout_valid is low.
REQ-019 SHALL drive tap k as all-zero while the fill count is below (k+1)*L, regardless of RAM contents.
REQ-020 SHALL saturate the fill count at TAPS*L and assert primed on the first dout_valid beat at which the count reaches that value.
REQ-021 SHALL clamp latched row_len below 2 to 2 and above MAX_LEN to MAX_LEN.
REQ-022 SHALL, on clr, re-latch row_len and zero ptr, the fill count, primed, dout_valid and col, with RAM contents left stale.
REQ-023 SHALL discard din_valid asserted in the same cycle as clr; the first beat after clr is the next din_valid.
REQ-024 SHALL leave the pending write issued in the cycle before clr harmless, since it is masked by REQ-019.

Reset
REQ-025 SHALL, on rstn low, asynchronously clear ptr, the fill count, primed, dout_valid, dout_tap, col and the pending-write register, and set latched L to clamp(MAX_LEN).
REQ-026 SHALL treat reset mid-row like clr: partial rows are lost and the first beat after release is column 0.

Configuration
REQ-027 SHALL, with LINE_BUFFER_OUT_REG_EN defined, add a register stage after the RAM read, making latency 2 cycles and dout_valid follow din_valid by 2.
REQ-028 SHALL, without LINE_BUFFER_OUT_REG_EN, have latency 1 cycle per REQ-018; the masking and primed timing rules are unchanged relative to dout_valid.

Structure
REQ-029 SHALL keep clamp constants, ADDR_W derivation and the tap-slice width function in shared package line_buffer_pkg.
REQ-030 SHALL place storage in one sub-module lb_sdp_ram: simple dual-port, MAX_LEN x TAPS*CH*DATA_W, synchronous read, 1-cycle latency, no output register, inferable as block RAM.

Verification
REQ-031 SHALL cover: row_len=4, TAPS=2, CH=2, 16 consecutive beats of value n -> beat 12 shows tap0=8, tap1=4; primed rises with beat 8; taps 0 before beats 4 and 8 respectively.
REQ-032 SHALL cover: row_len=4, din_valid toggled 1/0 for 24 cycles -> same tap values per beat as the continuous case; dout_valid tracks din_valid at a 1-cycle lag.
REQ-033 SHALL cover: row_len=1 and row_len=2000 -> behaves as L=2 and L=MAX_LEN; col wraps at 1 and at 1023.
REQ-034 SHALL cover: clr after 6 beats with row_len changed 4 -> 3 -> primed=0, col restarts at 0, tap0 zero for 3 beats, then correct at L=3.
REQ-035 SHALL cover: rstn pulsed low mid-row with din_valid high -> all outputs 0 immediately, refill identical to cold start.
REQ-036 SHALL cover: LINE_BUFFER_OUT_REG_EN defined, scenario REQ-031 repeated -> identical tap data at 2-cycle latency.
